// File: rtl/frame_assembler.sv
// frame_assembler: serializes one MP3 frame into a single byte stream.
// Byte order is header (4), CRC (0 or 2), side info (17 or 32), then main
// data for the rest of frame_size. This is the inverse of the decode-path
// frame byte demultiplexer.
//
// Optional feature: define MAIN_PAD_EN to enable main-data padding. When it
// is enabled, a main byte accepted with main_last=1 stops sourcing from the
// main stream. The rest of the frame is then filled with 0x00 bytes.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   frame_start              one-cycle pulse; latches header_word, mode, prot,
//                            frame_size and crc_word
//   header_word[31:0]        header bytes, MSB byte first
//   mode[1:0]                channel mode (3 = mono, 17 side bytes)
//   prot                     1 = no CRC, 0 = 2 CRC bytes
//   frame_size[10:0]         total frame bytes including header
//   crc_word[15:0]           CRC, MSB byte first
//   side_axiiv/d/r           side-info byte source (valid/data/ready)
//   main_axiiv/d/r           main-data byte source (valid/data/ready)
//   main_last                last available main byte (MAIN_PAD_EN only)
//   axiov/axiod/axior        output byte stream (valid/data/ready)
//   busy                     high from accepted frame_start until frame_done
//   frame_done               pulse when the final frame byte is accepted
//   size_err                 pulse when frame_start is rejected
module frame_assembler #(
    parameter int unsigned HDR_BYTES = 4,
    parameter int unsigned MAX_FRAME = 1441
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [31:0] header_word,
    input  logic [1:0]  mode,
    input  logic        prot,
    input  logic [10:0] frame_size,
    input  logic [15:0] crc_word,
    input  logic        side_axiiv,
    input  logic [7:0]  side_axiid,
    output logic        side_axiir,
    input  logic        main_axiiv,
    input  logic [7:0]  main_axiid,
    output logic        main_axiir,
    input  logic        main_last,
    output logic        axiov,
    output logic [7:0]  axiod,
    input  logic        axior,
    output logic        busy,
    output logic        frame_done,
    output logic        size_err
);

    localparam int unsigned CW = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CRC,
        S_SIDE,
        S_MAIN
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [31:0]   hdr_q;
    logic [15:0]   crc_q;
    logic          has_crc;
    logic [CW-1:0] side_len_q;
    logic [CW-1:0] main_len_q;
    logic          last_q;

    logic          can_load_c;
    logic          load_c;
    logic [7:0]    load_data_c;
    logic          last_load_c;
    logic          start_ok_c;
    logic          start_bad_c;
    logic [CW-1:0] crc_len_c;
    logic [CW-1:0] side_len_c;
    logic [CW-1:0] min_len_c;
    logic [CW-1:0] main_len_c;

`ifdef MAIN_PAD_EN
    logic          pad_q;
    logic          pad_set_c;
`else
    logic          unused_main_last;
    assign unused_main_last = main_last;
`endif

    // Section lengths derived from the frame_start inputs.
    always_comb begin
        crc_len_c  = prot ? CW'(0) : CW'(2);
        side_len_c = (mode == 2'd3) ? CW'(17) : CW'(32);
        min_len_c  = CW'(HDR_BYTES) + crc_len_c + side_len_c;
        main_len_c = frame_size - min_len_c;
    end

    // The output register may take a new byte when empty or being drained.
    assign can_load_c = !axiov || axior;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, byte selection and source readies.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        load_c      = 1'b0;
        load_data_c = 8'h00;
        last_load_c = 1'b0;
        start_ok_c  = 1'b0;
        start_bad_c = 1'b0;
        side_axiir  = 1'b0;
        main_axiir  = 1'b0;
`ifdef MAIN_PAD_EN
        pad_set_c   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                // busy is still high here while the final byte drains.
                if (frame_start && !busy) begin
                    if (frame_size < min_len_c || frame_size > CW'(MAX_FRAME)) begin
                        start_bad_c = 1'b1;
                    end else begin
                        start_ok_c = 1'b1;
                        state_nxt  = S_HDR;
                        cnt_nxt    = '0;
                    end
                end
            end
            S_HDR: begin
                if (can_load_c) begin
                    load_c      = 1'b1;
                    load_data_c = hdr_q[31:24];
                    if (cnt == CW'(HDR_BYTES - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = has_crc ? S_CRC : S_SIDE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_CRC: begin
                if (can_load_c) begin
                    load_c      = 1'b1;
                    load_data_c = crc_q[15:8];
                    if (cnt == CW'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = S_SIDE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_SIDE: begin
                side_axiir = can_load_c;
                if (side_axiiv && can_load_c) begin
                    load_c      = 1'b1;
                    load_data_c = side_axiid;
                    if (cnt == side_len_q - CW'(1)) begin
                        cnt_nxt = '0;
                        if (main_len_q == '0) begin
                            state_nxt   = S_IDLE;
                            last_load_c = 1'b1;
                        end else begin
                            state_nxt = S_MAIN;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_MAIN: begin
`ifdef MAIN_PAD_EN
                if (pad_q) begin
                    load_c      = can_load_c;
                    load_data_c = 8'h00;
                end else begin
                    main_axiir  = can_load_c;
                    load_c      = main_axiiv && can_load_c;
                    load_data_c = main_axiid;
                    // Padding starts only if bytes remain after this one.
                    if (load_c && main_last && (cnt != main_len_q - CW'(1))) begin
                        pad_set_c = 1'b1;
                    end
                end
`else
                main_axiir  = can_load_c;
                load_c      = main_axiiv && can_load_c;
                load_data_c = main_axiid;
`endif
                if (load_c) begin
                    if (cnt == main_len_q - CW'(1)) begin
                        cnt_nxt     = '0;
                        state_nxt   = S_IDLE;
                        last_load_c = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Frame context, output register and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_q      <= '0;
            crc_q      <= '0;
            has_crc    <= 1'b0;
            side_len_q <= '0;
            main_len_q <= '0;
            last_q     <= 1'b0;
            axiov      <= 1'b0;
            axiod      <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            size_err   <= 1'b0;
`ifdef MAIN_PAD_EN
            pad_q      <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            size_err   <= start_bad_c;

            if (start_ok_c) begin
                hdr_q      <= header_word;
                crc_q      <= crc_word;
                has_crc    <= !prot;
                side_len_q <= side_len_c;
                main_len_q <= main_len_c;
                busy       <= 1'b1;
                last_q     <= 1'b0;
`ifdef MAIN_PAD_EN
                pad_q      <= 1'b0;
`endif
            end

            // Header and CRC are shifted out MSB byte first.
            if (load_c && state == S_HDR) begin
                hdr_q <= {hdr_q[23:0], 8'h00};
            end
            if (load_c && state == S_CRC) begin
                crc_q <= {crc_q[7:0], 8'h00};
            end

`ifdef MAIN_PAD_EN
            if (pad_set_c) begin
                pad_q <= 1'b1;
            end
`endif

            if (load_c) begin
                axiov <= 1'b1;
                axiod <= load_data_c;
            end else if (axior) begin
                axiov <= 1'b0;
            end

            // last_q marks that the byte in the output register ends the frame.
            if (last_load_c) begin
                last_q <= 1'b1;
            end
            if (axiov && axior && last_q) begin
                last_q     <= 1'b0;
                frame_done <= 1'b1;
                busy       <= 1'b0;
            end
        end
    end

endmodule
